mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares the single data-cache port between two sources: loads issued from `load_data_queue` and retired stores drained from the store data queue (SDQ).
- Keeps at most one cache transaction in flight.
- Routes load responses back, tagged with the LDQ index.
- Sits between LDQ/SDQ heads and the D-cache.
- Gives loads priority, except when SDQ pressure or store starvation forces a store grant.

## Interface
Parameters:
- `LDQ_IDX_W`, default `$clog2(LDQ_ENTRIES)`, LDQ index width.
- `SDQ_CNT_W`, default `$clog2(SDQ_ENTRIES)+1`, SDQ occupancy width.
- `STORE_HI_WM`, default `SDQ_ENTRIES-2`, occupancy at/above which stores win.
- `STARVE_LIMIT`, default 8, load grants tolerated while a store waits (≥1).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; asynchronous, active-low.
- `ld_vld_i` in 1: LDQ head load ready (from `issue_vld_o`).
- `ld_addr_i` in 32: load address.
- `ld_idx_i` in `LDQ_IDX_W`: LDQ index of head load.
- `ld_issue_en_o` out 1: one-cycle pop strobe to LDQ (`issue_en_i`).
- `st_vld_i` in 1: retired store at SDQ head.
- `st_addr_i` in 32: store address.
- `st_data_i` in 32: store data.
- `st_be_i` in 4: store byte enables.
- `st_pop_o` out 1: one-cycle SDQ pop strobe.
- `sdq_count_i` in `SDQ_CNT_W`: SDQ occupancy.
- `flush_i` in 1: squash all speculative loads.
- `dc_req_o` out 1: cache request valid.
- `dc_we_o` out 1: 1 = store.
- `dc_addr_o` out 32: request address.
- `dc_wdata_o` out 32: store data.
- `dc_be_o` out 4: store byte enables (`4'b0000` for loads).
- `dc_gnt_i` in 1: cache accepts request.
- `dc_rvld_i` in 1: load data returning.
- `dc_rdata_i` in 32: load data.
- `ld_resp_vld_o` out 1: load result valid.
- `ld_resp_idx_o` out `LDQ_IDX_W`: LDQ index of result.
- `ld_resp_data_o` out 32: load result data.

## Operation
FSM with three states: IDLE, REQ, WAIT.

IDLE:
- A candidate exists when `st_vld_i`, or `ld_vld_i && !flush_i`.
- Choose store if `st_vld_i && (sdq_count_i >= STORE_HI_WM || !(ld_vld_i && !flush_i) || starve_cnt == STARVE_LIMIT)`; otherwise choose load.
- Latch `dc_we_o`, `dc_addr_o`, `dc_wdata_o`, `dc_be_o` and the load index; go to REQ.

REQ:
- `dc_req_o`=1, with fields held stable until `dc_gnt_i`.
- On grant, in the same cycle, pulse `st_pop_o` for a store or `ld_issue_en_o` for a load (combinational from `state==REQ && dc_gnt_i`).
- After grant: store → IDLE; load → WAIT.
- `dc_rvld_i` is ignored in REQ.

WAIT:
- On `dc_rvld_i`: register the response and go to IDLE.
- `ld_resp_vld_o` pulses one cycle later with the latched index and `dc_rdata_i`, unless the load was killed.

Starvation counter:
- `starve_cnt`, saturating at `STARVE_LIMIT`.
- +1 on each load grant while `st_vld_i`=1.
- Cleared on each store grant.

Flush:
- A `flush_i` while a load is in REQ or WAIT sets `killed`.
- The request still completes (a request is never withdrawn once asserted); its response is suppressed.
- `killed` clears on return to IDLE.
- Stores are never affected by flush.

`dc_gnt_i`/`dc_rvld_i` outside their states are ignored.

## Timing
- Reset values:
  - `state`=IDLE, `starve_cnt`=0, `killed`=0.
  - `dc_req_o`, `dc_we_o`, `ld_issue_en_o`, `st_pop_o`, `ld_resp_vld_o` = 0.
  - `dc_addr_o`, `dc_wdata_o`, `ld_resp_data_o` = 0; `dc_be_o`=0; `ld_resp_idx_o`=0.
- Reset asserted mid-transaction aborts immediately. No pop or response is emitted.
- Store with immediate grant: candidate at edge N, `dc_req_o` high in cycle N+1, `st_pop_o` in N+1, back in IDLE at N+2. That gives 2 cycles/store.
- Load with immediate grant and response:
  - REQ in N+1 (pop in N+1).
  - WAIT sees `dc_rvld_i` at earliest N+2.
  - `ld_resp_vld_o` in N+3.
  - Next request no earlier than N+4.
- Sources must hold their head stable until popped. The arbiter samples the head only in IDLE.
- A simultaneous `flush_i` and `dc_rvld_i` in WAIT suppresses the response.

## Configuration
`MEM_ARB_STARVE_GUARD_EN`:
- Defined: the starvation counter is present and forces a store grant at `STARVE_LIMIT`.
- Undefined: the counter is removed. Stores win only when `sdq_count_i >= STORE_HI_WM` or no load candidate exists (strict load priority otherwise).

## Test plan
- **Single load:** `ld_vld_i`=1, idx=5, addr=0x1000; `dc_gnt_i` tied 1; `dc_rdata_i`=0xDEADBEEF one cycle after grant. Expect: `ld_issue_en_o` one pulse, `dc_we_o`=0, then `ld_resp_vld_o` with idx=5, data=0xDEADBEEF.
- **Priority:** load and store both valid, `sdq_count_i`=2. Expect load first. Repeat with `sdq_count_i`=`STORE_HI_WM`: expect store first (`dc_we_o`=1, `st_pop_o` pulse, `dc_be_o`=`st_be_i`).
- **Starvation (macro defined):** loads continuously valid, store valid, `sdq_count_i`=1. Expect exactly 8 load grants, then a store grant, then `starve_cnt`=0. Macro undefined: no store grant while loads remain valid.
- **Grant backpressure:** hold `dc_gnt_i`=0 for 4 cycles. Expect `dc_req_o` and all fields stable and no pop until `dc_gnt_i`=1.
- **Flush:** assert `flush_i` while a load is in WAIT. Expect the request completes and there is no `ld_resp_vld_o`. Assert `flush_i` in IDLE with only `ld_vld_i`: expect no request that cycle.
- **Async reset:** drop `rst_ni` in REQ. Expect `dc_req_o`=0 immediately and no pop or response after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the single D-cache port between LDQ head loads and SDQ head stores, one transaction in flight.
// Optional store-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int LDQ_ENTRIES  = 16,
    parameter int SDQ_ENTRIES  = 8,
    parameter int LDQ_IDX_W    = $clog2(LDQ_ENTRIES),
    parameter int SDQ_CNT_W    = $clog2(SDQ_ENTRIES) + 1,
    parameter int STORE_HI_WM  = SDQ_ENTRIES - 2,
    parameter int STARVE_LIMIT = 8,
    localparam int STARVE_W    = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ld_vld_i,
    input  logic [31:0]          ld_addr_i,
    input  logic [LDQ_IDX_W-1:0] ld_idx_i,
    output logic                 ld_issue_en_o,
    input  logic                 st_vld_i,
    input  logic [31:0]          st_addr_i,
    input  logic [31:0]          st_data_i,
    input  logic [3:0]           st_be_i,
    output logic                 st_pop_o,
    input  logic [SDQ_CNT_W-1:0] sdq_count_i,
    input  logic                 flush_i,
    output logic                 dc_req_o,
    output logic                 dc_we_o,
    output logic [31:0]          dc_addr_o,
    output logic [31:0]          dc_wdata_o,
    output logic [3:0]           dc_be_o,
    input  logic                 dc_gnt_i,
    input  logic                 dc_rvld_i,
    input  logic [31:0]          dc_rdata_i,
    output logic                 ld_resp_vld_o,
    output logic [LDQ_IDX_W-1:0] ld_resp_idx_o,
    output logic [31:0]          ld_resp_data_o,
    output logic [1:0]           dbg_state_o,
    output logic [STARVE_W-1:0]  dbg_starve_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [SDQ_CNT_W-1:0] HI_WM_V = SDQ_CNT_W'(STORE_HI_WM);

    state_t                 state_q, state_d;
    logic                   we_q;
    logic [31:0]            addr_q;
    logic [31:0]            wdata_q;
    logic [3:0]             be_q;
    logic [LDQ_IDX_W-1:0]   idx_q;
    logic                   killed_q;
    logic                   resp_vld_q;
    logic [LDQ_IDX_W-1:0]   resp_idx_q;
    logic [31:0]            resp_data_q;

    logic ld_cand;
    logic candidate;
    logic starve_force;
    logic pick_store;
    logic grant;

    assign ld_cand    = ld_vld_i && !flush_i;
    assign candidate  = st_vld_i || ld_cand;
    assign pick_store = st_vld_i && ((sdq_count_i >= HI_WM_V) || !ld_cand || starve_force);
    assign grant      = (state_q == S_REQ) && dc_gnt_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [STARVE_W-1:0] STARVE_LIMIT_V = STARVE_W'(STARVE_LIMIT);
    logic [STARVE_W-1:0] starve_q;

    // Counts load grants that bypassed a waiting store; saturates so the force stays asserted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else if (grant) begin
            if (we_q) begin
                starve_q <= '0;
            end else if (st_vld_i && (starve_q != STARVE_LIMIT_V)) begin
                starve_q <= starve_q + STARVE_W'(1);
            end
        end
    end

    assign starve_force     = (starve_q == STARVE_LIMIT_V);
    assign dbg_starve_cnt_o = starve_q;
`else
    assign starve_force     = 1'b0;
    assign dbg_starve_cnt_o = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        dc_req_o      = 1'b0;
        ld_issue_en_o = 1'b0;
        st_pop_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (candidate) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                dc_req_o = 1'b1;
                if (dc_gnt_i) begin
                    if (we_q) begin
                        st_pop_o = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        ld_issue_en_o = 1'b1;
                        state_d       = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dc_rvld_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are captured only in IDLE, so they stay frozen through REQ backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            idx_q       <= '0;
            killed_q    <= 1'b0;
            resp_vld_q  <= 1'b0;
            resp_idx_q  <= '0;
            resp_data_q <= '0;
        end else begin
            resp_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    killed_q <= 1'b0;
                    if (candidate) begin
                        we_q    <= pick_store;
                        addr_q  <= pick_store ? st_addr_i : ld_addr_i;
                        wdata_q <= pick_store ? st_data_i : '0;
                        be_q    <= pick_store ? st_be_i : 4'b0000;
                        if (!pick_store) begin
                            idx_q <= ld_idx_i;
                        end
                    end
                end
                S_REQ: begin
                    if (!we_q && flush_i) begin
                        killed_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (dc_rvld_i) begin
                        resp_vld_q  <= !killed_q && !flush_i;
                        resp_idx_q  <= idx_q;
                        resp_data_q <= dc_rdata_i;
                        killed_q    <= 1'b0;
                    end else if (flush_i) begin
                        killed_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dc_we_o        = we_q;
    assign dc_addr_o      = addr_q;
    assign dc_wdata_o     = wdata_q;
    assign dc_be_o        = be_q;
    assign ld_resp_vld_o  = resp_vld_q;
    assign ld_resp_idx_o  = resp_idx_q;
    assign ld_resp_data_o = resp_data_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-vector table plus starvation and async-reset sequences.
// Honours MEM_ARB_STARVE_GUARD_EN for the starvation expectation.
module tb_mem_port_arbiter;

    localparam logic [31:0] ST_ADDR = 32'h0000_2000;
    localparam logic [31:0] ST_DATA = 32'hCAFE_F00D;
    localparam logic [3:0]  ST_BE   = 4'b0110;

    logic        clk_i;
    logic        rst_ni;
    logic        ld_vld_i;
    logic [31:0] ld_addr_i;
    logic [3:0]  ld_idx_i;
    logic        ld_issue_en_o;
    logic        st_vld_i;
    logic [31:0] st_addr_i;
    logic [31:0] st_data_i;
    logic [3:0]  st_be_i;
    logic        st_pop_o;
    logic [3:0]  sdq_count_i;
    logic        flush_i;
    logic        dc_req_o;
    logic        dc_we_o;
    logic [31:0] dc_addr_o;
    logic [31:0] dc_wdata_o;
    logic [3:0]  dc_be_o;
    logic        dc_gnt_i;
    logic        dc_rvld_i;
    logic [31:0] dc_rdata_i;
    logic        ld_resp_vld_o;
    logic [3:0]  ld_resp_idx_o;
    logic [31:0] ld_resp_data_o;
    logic [1:0]  dbg_state_o;
    logic [3:0]  dbg_starve_cnt_o;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .ld_vld_i         (ld_vld_i),
        .ld_addr_i        (ld_addr_i),
        .ld_idx_i         (ld_idx_i),
        .ld_issue_en_o    (ld_issue_en_o),
        .st_vld_i         (st_vld_i),
        .st_addr_i        (st_addr_i),
        .st_data_i        (st_data_i),
        .st_be_i          (st_be_i),
        .st_pop_o         (st_pop_o),
        .sdq_count_i      (sdq_count_i),
        .flush_i          (flush_i),
        .dc_req_o         (dc_req_o),
        .dc_we_o          (dc_we_o),
        .dc_addr_o        (dc_addr_o),
        .dc_wdata_o       (dc_wdata_o),
        .dc_be_o          (dc_be_o),
        .dc_gnt_i         (dc_gnt_i),
        .dc_rvld_i        (dc_rvld_i),
        .dc_rdata_i       (dc_rdata_i),
        .ld_resp_vld_o    (ld_resp_vld_o),
        .ld_resp_idx_o    (ld_resp_idx_o),
        .ld_resp_data_o   (ld_resp_data_o),
        .dbg_state_o      (dbg_state_o),
        .dbg_starve_cnt_o (dbg_starve_cnt_o)
    );

    // Clock and reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        ld_vld;
        logic [3:0]  idx;
        logic [31:0] ld_addr;
        logic        st_vld;
        logic [3:0]  sdq;
        logic        flush;
        logic        gnt;
        logic        rvld;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_iss;
        logic        e_pop;
        logic        e_rvld;
        logic [3:0]  e_idx;
        logic [31:0] e_data;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic drive_idle();
        ld_vld_i    = 1'b0;
        ld_addr_i   = '0;
        ld_idx_i    = '0;
        st_vld_i    = 1'b0;
        st_addr_i   = ST_ADDR;
        st_data_i   = ST_DATA;
        st_be_i     = ST_BE;
        sdq_count_i = '0;
        flush_i     = 1'b0;
        dc_gnt_i    = 1'b0;
        dc_rvld_i   = 1'b0;
        dc_rdata_i  = '0;
    endtask

    task automatic apply(input vec_t v);
        ld_vld_i    = v.ld_vld;
        ld_idx_i    = v.idx;
        ld_addr_i   = v.ld_addr;
        st_vld_i    = v.st_vld;
        sdq_count_i = v.sdq;
        flush_i     = v.flush;
        dc_gnt_i    = v.gnt;
        dc_rvld_i   = v.rvld;
        dc_rdata_i  = v.rdata;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #2;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        drive_idle();
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_req"},  {31'd0, dc_req_o},      32'd0);
        chk({tag, "_iss"},  {31'd0, ld_issue_en_o}, 32'd0);
        chk({tag, "_pop"},  {31'd0, st_pop_o},      32'd0);
        chk({tag, "_resp"}, {31'd0, ld_resp_vld_o}, 32'd0);
    endtask

    initial begin
        int n_iss;
        int n_pop;
        int pops_seen;
        string tag;

        // Single load, priority at low/high SDQ pressure with grant backpressure, flush in WAIT and IDLE
        vecs[0]  = '{1'b1, 4'd5, 32'h1000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[1]  = '{1'b1, 4'd5, 32'h1000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1000, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[2]  = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[3]  = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b1, 4'd5, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 4'd3, 32'h1100, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[5]  = '{1'b1, 4'd3, 32'h1100, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1100, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[6]  = '{1'b0, 4'd0, 32'h0,    1'b1, 4'd2, 1'b0, 1'b1, 1'b1, 32'h11112222, 1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[7]  = '{1'b0, 4'd0, 32'h0,    1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b1, 4'd3, 32'h11112222};
        vecs[8]  = '{1'b0, 4'd0, 32'h0,    1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, ST_ADDR,  ST_BE, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0};
        vecs[9]  = '{1'b1, 4'd7, 32'h1200, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[10] = '{1'b1, 4'd7, 32'h1200, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, ST_ADDR,  ST_BE, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[11] = vecs[10];
        vecs[12] = vecs[10];
        vecs[13] = vecs[10];
        vecs[14] = '{1'b1, 4'd7, 32'h1200, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, ST_ADDR,  ST_BE, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0};
        vecs[15] = '{1'b1, 4'd7, 32'h1200, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[16] = '{1'b1, 4'd7, 32'h1200, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1200, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[17] = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[18] = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 32'h55,       1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[19] = '{1'b1, 4'd2, 32'h1300, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[20] = '{1'b1, 4'd2, 32'h1300, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[21] = '{1'b1, 4'd2, 32'h1300, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1300, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[22] = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 32'h77,       1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};
        vecs[23] = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0};

        // Reset values, checked while reset is held
        rst_ni = 1'b0;
        drive_idle();
        #1;
        check_quiet("rst");
        next_cycle();
        chk("rst_we",     {31'd0, dc_we_o}, 32'd0);
        chk("rst_addr",   dc_addr_o,        32'd0);
        chk("rst_wdata",  dc_wdata_o,       32'd0);
        chk("rst_be",     {28'd0, dc_be_o}, 32'd0);
        chk("rst_ridx",   {28'd0, ld_resp_idx_o}, 32'd0);
        chk("rst_rdata",  ld_resp_data_o,   32'd0);
        chk("rst_state",  {30'd0, dbg_state_o}, 32'd0);
        chk("rst_starve", {28'd0, dbg_starve_cnt_o}, 32'd0);
        next_cycle();
        rst_ni = 1'b1;

        // Vector table
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i]);
            #1;
            tag = $sformatf("v%0d", i);
            chk({tag, "_req"},  {31'd0, dc_req_o},      {31'd0, vecs[i].e_req});
            chk({tag, "_iss"},  {31'd0, ld_issue_en_o}, {31'd0, vecs[i].e_iss});
            chk({tag, "_pop"},  {31'd0, st_pop_o},      {31'd0, vecs[i].e_pop});
            chk({tag, "_resp"}, {31'd0, ld_resp_vld_o}, {31'd0, vecs[i].e_rvld});
            if (vecs[i].e_req) begin
                chk({tag, "_we"},   {31'd0, dc_we_o}, {31'd0, vecs[i].e_we});
                chk({tag, "_addr"}, dc_addr_o,        vecs[i].e_addr);
                chk({tag, "_be"},   {28'd0, dc_be_o}, {28'd0, vecs[i].e_be});
                chk({tag, "_wdata"}, dc_wdata_o, vecs[i].e_we ? ST_DATA : 32'h0);
            end
            if (vecs[i].e_rvld) begin
                chk({tag, "_ridx"},  {28'd0, ld_resp_idx_o}, {28'd0, vecs[i].e_idx});
                chk({tag, "_rdata"}, ld_resp_data_o,         vecs[i].e_data);
            end
            next_cycle();
        end

        // Starvation: loads always ready, store waiting at low SDQ pressure
        do_reset();
        ld_vld_i    = 1'b1;
        ld_idx_i    = 4'd1;
        ld_addr_i   = 32'h3000;
        st_vld_i    = 1'b1;
        sdq_count_i = 4'd1;
        dc_gnt_i    = 1'b1;
        dc_rvld_i   = 1'b1;
        dc_rdata_i  = 32'h1234;
        n_iss = 0;
        n_pop = 0;
        pops_seen = 0;
        for (int c = 0; c < 60 && pops_seen == 0; c++) begin
            next_cycle();
            if (ld_issue_en_o) n_iss++;
            if (st_pop_o) begin
                n_pop++;
                pops_seen = 1;
            end
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("starve_pop_seen",   n_pop, 1);
        chk("starve_load_grants", n_iss, 8);
        next_cycle();
        chk("starve_cnt_clear", {28'd0, dbg_starve_cnt_o}, 32'd0);
`else
        chk("strict_no_store",   n_pop, 0);
        chk("strict_loads_flow", {31'd0, n_iss >= 8}, 32'd1);
`endif

        // Async reset in REQ aborts at once, no pop or response afterwards
        do_reset();
        ld_vld_i  = 1'b1;
        ld_idx_i  = 4'd9;
        ld_addr_i = 32'h4000;
        dc_gnt_i  = 1'b0;
        next_cycle();
        chk("arst_in_req", {31'd0, dc_req_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("arst_req_drop", {31'd0, dc_req_o}, 32'd0);
        chk("arst_state",    {30'd0, dbg_state_o}, 32'd0);
        drive_idle();
        dc_gnt_i   = 1'b1;
        dc_rvld_i  = 1'b1;
        dc_rdata_i = 32'hBAD0BAD0;
        next_cycle();
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            check_quiet($sformatf("arst_post%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
